// File: rtl/imm_gen_pipe.sv
// RISC-V decode-stage immediate generator.
// Registered output with a one-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit RV64 = (XLEN == 64);

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5,
    T_Z    = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [6:0]  op;
  logic        is_i, is_s, is_b, is_u;
  logic        is_j, is_z, is_nop;
  logic [31:0] imm32;
  imm_type_e   typ;
  logic        ill;
  ent_t        dec;

  ent_t out_q, skid_q;
  logic skid_valid;
  logic in_fire;

  assign op = instr[6:0];

  assign is_i = (op == 7'b0000011)
             || (op == 7'b0010011)
             || (op == 7'b1100111)
             || (RV64 && op == 7'b0011011);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111)
             || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);
  assign is_z = (op == 7'b1110011) && instr[14];
  // Recognised opcodes that carry no immediate
  assign is_nop = ((op == 7'b1110011) && !instr[14])
               || (op == 7'b0001111)
               || (op == 7'b0110011)
               || (RV64 && op == 7'b0111011);

  always_comb begin
    imm32 = '0;
    typ   = T_NONE;
    ill   = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        typ   = T_I;
      end
      is_s: begin
        imm32 = {{20{instr[31]}}, instr[31:25],
                 instr[11:7]};
        typ   = T_S;
      end
      is_b: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
        typ   = T_B;
      end
      is_u: begin
        imm32 = {instr[31:12], 12'h000};
        typ   = T_U;
      end
      is_j: begin
        imm32 = {{11{instr[31]}}, instr[31],
                 instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        typ   = T_J;
      end
      is_z: begin
        imm32 = {27'd0, instr[19:15]};
        typ   = T_Z;
      end
      is_nop: ;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.imm = XLEN'($signed(imm32));
    dec.typ = typ;
    dec.ill = ill;
    dec.tag = in_tag;
  end

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_imm     = out_q.imm;
  assign out_type    = out_q.typ;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe.
// Drives XLEN=32 and XLEN=64 instances in lockstep.
module tb_imm_gen_pipe;

  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] TI   = 3'd1;
  localparam logic [2:0] TS   = 3'd2;
  localparam logic [2:0] TB   = 3'd3;
  localparam logic [2:0] TU   = 3'd4;
  localparam logic [2:0] TJ   = 3'd5;
  localparam logic [2:0] TZ   = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        r32, v32, l32;
  logic [31:0] i32, g32;
  logic [2:0]  t32;
  logic        r64, v64, l64;
  logic [63:0] i64;
  logic [31:0] g64;
  logic [2:0]  t64;

  typedef struct {
    logic [31:0] tag;
    logic [31:0] i32;
    logic [2:0]  t32;
    logic        l32;
    logic [63:0] i64;
    logic [2:0]  t64;
    logic        l64;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  int   n_vec = 0;
  int   n_err = 0;
  bit   acc;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32),
    .instr(instr), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(i32), .out_type(t32),
    .out_illegal(l32), .out_tag(g32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .instr(instr), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(i64), .out_type(t64),
    .out_illegal(l64), .out_tag(g64)
  );

  task automatic chk(string nm, logic [63:0] obs,
                     logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             nm, obs, exp);
    end
  endtask

  // One clock: scoreboard acts at the falling edge
  task automatic cyc(output bit a);
    exp_t e;
    a = 1'b0;
    @(negedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (v32 && out_ready) begin
        n_vec++;
        assert (q.size() > 0) else begin
          n_err++;
          $error("FAIL spurious_out observed=%0h expected=none",
                 g32);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("tag32", {32'd0, g32}, {32'd0, e.tag});
          chk("imm32", {32'd0, i32}, {32'd0, e.i32});
          chk("typ32", {61'd0, t32}, {61'd0, e.t32});
          chk("ill32", {63'd0, l32}, {63'd0, e.l32});
          chk("vld64", {63'd0, v64}, 64'd1);
          chk("tag64", {32'd0, g64}, {32'd0, e.tag});
          chk("imm64", i64, e.i64);
          chk("typ64", {61'd0, t64}, {61'd0, e.t64});
          chk("ill64", {63'd0, l64}, {63'd0, e.l64});
        end
      end
      if (in_valid && r32) begin
        q.push_back(nxt);
        a = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put2(logic [31:0] ins, logic [31:0] tg,
                      logic [31:0] e32, logic [2:0] ty32,
                      logic il32, logic [63:0] e64,
                      logic [2:0] ty64, logic il64);
    instr    = ins;
    in_tag   = tg;
    nxt.tag  = tg;
    nxt.i32  = e32;
    nxt.t32  = ty32;
    nxt.l32  = il32;
    nxt.i64  = e64;
    nxt.t64  = ty64;
    nxt.l64  = il64;
  endtask

  task automatic put(logic [31:0] ins, logic [31:0] tg,
                     logic [31:0] e32, logic [2:0] ty,
                     logic il);
    put2(ins, tg, e32, ty, il,
         {{32{e32[31]}}, e32}, ty, il);
  endtask

  task automatic send();
    bit a;
    a = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(a);
      if (a) break;
    end
    in_valid = 1'b0;
    chk("send_accept", {63'd0, a}, 64'd1);
  endtask

  task automatic idle(int n);
    bit a;
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cyc(a);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    instr = '0; in_tag = '0; out_ready = 1'b0;
    nxt = '{default: '0};
    #3;
    chk("rst_valid", {63'd0, v32}, 64'd0);
    chk("rst_ready", {63'd0, r32}, 64'd1);
    chk("rst_imm", i64, 64'd0);
    chk("rst_type", {61'd0, t32}, 64'd0);
    chk("rst_ill", {63'd0, l32}, 64'd0);
    chk("rst_tag", {32'd0, g32}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate stream, one-cycle latency
    out_ready = 1'b1;
    put(32'h6cdff6e7, 1, 32'h0000_06cd, TI, 0); send();
    put(32'h02dff6a3, 2, 32'h0000_002d, TS, 0); send();
    put(32'h75834863, 3, 32'h0000_0750, TB, 0); send();
    put(32'h12345637, 4, 32'h1234_5000, TU, 0); send();
    put(32'h6669996f, 5, 32'h0009_9666, TJ, 0); send();
    idle(1);
    chk("t1_drained", q.size(), 64'd0);

    put(32'h8cdff603, 6, 32'hffff_f8cd, TI, 0); send();
    put(32'habcdef97, 7, 32'habcd_e000, TU, 0); send();
    put(32'h888888ef, 8, 32'hfff8_8088, TJ, 0); send();
    put(32'h00000000, 9, 32'h0, NONE, 1); send();
    put(32'h0020d073, 10, 32'h1, TZ, 0); send();
    put(32'h30001073, 11, 32'h0, NONE, 0); send();
    put(32'h0000000f, 12, 32'h0, NONE, 0); send();
    put(32'h00b50533, 13, 32'h0, NONE, 0); send();
    put(32'h0000007f, 14, 32'h0, NONE, 1); send();
    put2(32'h0010009b, 15, 32'h0, NONE, 1,
         64'h1, TI, 0); send();
    put2(32'h0000003b, 16, 32'h0, NONE, 1,
         64'h0, NONE, 0); send();
    idle(1);
    chk("t2_drained", q.size(), 64'd0);

    // Backpressure: output + skid fill, third waits
    out_ready = 1'b0;
    put(32'h00100093, 21, 32'h1, TI, 0); send();
    put(32'h00200093, 22, 32'h2, TI, 0); send();
    put(32'h00300093, 23, 32'h3, TI, 0);
    in_valid = 1'b1;
    cyc(acc);
    chk("t3_held_acc", {63'd0, acc}, 64'd0);
    chk("t3_ready", {63'd0, r32}, 64'd0);
    chk("t3_valid", {63'd0, v32}, 64'd1);
    chk("t3_tag", {32'd0, g32}, 64'd21);
    cyc(acc);
    chk("t3_stable_tag", {32'd0, g32}, 64'd21);
    chk("t3_stable_imm", i64, 64'd1);
    out_ready = 1'b1;
    send();
    idle(3);
    chk("t3_drained", q.size(), 64'd0);

    // Flush with full buffers
    out_ready = 1'b0;
    put(32'h00a00093, 31, 32'ha, TI, 0); send();
    put(32'h00b00093, 32, 32'hb, TI, 0); send();
    put(32'h00c00093, 33, 32'hc, TI, 0);
    in_valid = 1'b1; flush = 1'b1;
    cyc(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", {63'd0, v32}, 64'd0);
    chk("t5_ready", {63'd0, r32}, 64'd1);
    chk("t5_tag_held", {32'd0, g32}, 64'd31);
    chk("t5_imm_held", i64, 64'ha);
    // Flush while the stage could accept
    out_ready = 1'b1;
    put(32'h00d00093, 34, 32'hd, TI, 0);
    in_valid = 1'b1; flush = 1'b1;
    cyc(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_drop_valid", {63'd0, v32}, 64'd0);
    idle(2);
    chk("t5_no_ghost", {63'd0, v32}, 64'd0);
    put(32'h00e00093, 35, 32'he, TI, 0); send();
    idle(1);
    chk("t5_drained", q.size(), 64'd0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    put(32'h00f00093, 41, 32'hf, TI, 0); send();
    put(32'h01000093, 42, 32'h10, TI, 0); send();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("t6_valid", {63'd0, v32}, 64'd0);
    chk("t6_ready", {63'd0, r32}, 64'd1);
    chk("t6_tag", {32'd0, g32}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    put(32'hfff00093, 43, 32'hffff_ffff, TI, 0); send();
    chk("t6_lat_valid", {63'd0, v32}, 64'd1);
    idle(1);
    chk("t6_drained", q.size(), 64'd0);

    idle(4);
    chk("final_empty", q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
